// File: rtl/memoria_dados_resposta.sv
// memoria_dados_resposta
// Responder side of the processor data-memory bus. It services one read or
// write at a time against an internal word array. Each access passes through
// LATENCIA wait states and then signals completion with a one-cycle pronto pulse.
// Optional feature: define MEMORIA_PROTECAO_EN to add the per-word write-protect
// input protecao. A protected write keeps the normal timing, leaves the array
// unchanged, and raises erro together with pronto.
module memoria_dados_resposta #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  parameter int LATENCIA = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    endereco,
  input  logic [DATA_W-1:0]    valor_escrita,
  input  logic                 leitura,
  input  logic                 escrita,
`ifdef MEMORIA_PROTECAO_EN
  input  logic [2**ADDR_W-1:0] protecao,
`endif
  output logic [DATA_W-1:0]    valor_saida,
  output logic                 pronto,
  output logic                 ocupado,
  output logic                 erro
);

  localparam int         PROF = 2 ** ADDR_W;
  localparam logic [3:0] LAT  = 4'(LATENCIA);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESPERA   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [3:0]          contador_q, contador_d;
  logic                op_escrita_q, op_escrita_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DATA_W-1:0]   dado_q, dado_d;
  logic                prot_q, prot_d;
  logic                pronto_q, pronto_d;
  logic                erro_q, erro_d;
  logic [DATA_W-1:0]   valor_saida_q, valor_saida_d;
  logic [DATA_W-1:0]   mem_q [PROF];

  // Access being completed on this edge. In OCIOSO with zero latency it comes
  // straight from the inputs; otherwise it comes from the latched request.
  logic                commit;
  logic                commit_esc;
  logic [ADDR_W-1:0]   commit_end;
  logic [DATA_W-1:0]   commit_dado;
  logic                commit_prot;
  logic                mem_we;

  logic                pedido_valido;
  logic                colisao;
  logic                prot_amostra;

  assign pedido_valido = leitura ^ escrita;
  assign colisao       = leitura & escrita;

`ifdef MEMORIA_PROTECAO_EN
  assign prot_amostra = protecao[endereco];
`else
  assign prot_amostra = 1'b0;
`endif

  // Next-state logic: request acceptance, wait-state countdown, completion.
  always_comb begin
    estado_d      = estado_q;
    contador_d    = contador_q;
    op_escrita_d  = op_escrita_q;
    end_d         = end_q;
    dado_d        = dado_q;
    prot_d        = prot_q;
    pronto_d      = 1'b0;
    erro_d        = 1'b0;
    commit        = 1'b0;
    commit_esc    = op_escrita_q;
    commit_end    = end_q;
    commit_dado   = dado_q;
    commit_prot   = prot_q;

    case (estado_q)
      OCIOSO: begin
        if (pedido_valido) begin
          op_escrita_d = escrita;
          end_d        = endereco;
          dado_d       = valor_escrita;
          prot_d       = prot_amostra & escrita;
          if (LAT == 4'd0) begin
            estado_d    = RESPOSTA;
            commit      = 1'b1;
            commit_esc  = escrita;
            commit_end  = endereco;
            commit_dado = valor_escrita;
            commit_prot = prot_amostra & escrita;
          end else begin
            estado_d   = ESPERA;
            contador_d = LAT;
          end
        end else if (colisao) begin
          erro_d = 1'b1;
        end
      end
      ESPERA: begin
        if (contador_q == 4'd1) begin
          estado_d   = RESPOSTA;
          contador_d = 4'd0;
          commit     = 1'b1;
        end else begin
          contador_d = contador_q - 4'd1;
        end
      end
      RESPOSTA: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    if (commit) begin
      pronto_d = 1'b1;
      if (commit_esc && commit_prot) begin
        erro_d = 1'b1;
      end
    end
  end

  // Array write enable and read-data update for the completing access.
  always_comb begin
    mem_we        = commit & commit_esc & ~commit_prot;
    valor_saida_d = valor_saida_q;
    if (commit && !commit_esc) begin
      valor_saida_d = mem_q[commit_end];
    end
  end

  // Control and output registers. Reset aborts any access that is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q      <= OCIOSO;
      contador_q    <= 4'd0;
      op_escrita_q  <= 1'b0;
      end_q         <= '0;
      dado_q        <= '0;
      prot_q        <= 1'b0;
      pronto_q      <= 1'b0;
      erro_q        <= 1'b0;
      valor_saida_q <= '0;
    end else begin
      estado_q      <= estado_d;
      contador_q    <= contador_d;
      op_escrita_q  <= op_escrita_d;
      end_q         <= end_d;
      dado_q        <= dado_d;
      prot_q        <= prot_d;
      pronto_q      <= pronto_d;
      erro_q        <= erro_d;
      valor_saida_q <= valor_saida_d;
    end
  end

  // Word array. It is cleared on reset, so a pending write is simply lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROF; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[commit_end] <= commit_dado;
    end
  end

  assign valor_saida = valor_saida_q;
  assign pronto      = pronto_q;
  assign erro        = erro_q;
  assign ocupado     = (estado_q != OCIOSO);

endmodule

// File: tb/tb_memoria_dados_resposta.sv
// Testbench for memoria_dados_resposta. It runs two instances: one with
// LATENCIA=2 and one with LATENCIA=0. Stimulus pushes expected responses into
// per-instance queues, and a forked monitor pops and checks them whenever an
// instance raises pronto or erro.
module tb_memoria_dados_resposta;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0][2:0] ea;
  logic [1:0][7:0] wd;
  logic [1:0]      rd, wr;
  logic [1:0][7:0] vs;
  logic [1:0]      pr, oc, er;
`ifdef MEMORIA_PROTECAO_EN
  logic [1:0][7:0] prot;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    memoria_dados_resposta #(
      .ADDR_W(3), .DATA_W(8), .LATENCIA((gi == 0) ? 2 : 0)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .endereco     (ea[gi]),
      .valor_escrita(wd[gi]),
      .leitura      (rd[gi]),
      .escrita      (wr[gi]),
`ifdef MEMORIA_PROTECAO_EN
      .protecao     (prot[gi]),
`endif
      .valor_saida  (vs[gi]),
      .pronto       (pr[gi]),
      .ocupado      (oc[gi]),
      .erro         (er[gi])
    );
  end

  typedef struct {
    bit         leit;
    bit         so_erro;
    bit         prot;
    logic [7:0] dado;
    int         ciclo;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] model [2][8];
  logic [7:0] last_read [2];
  int         checks = 0;
  int         errors = 0;

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(string nome, int k, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", nome, k, act, exp_v, cyc);
    end
  endtask

  task automatic push(int k, exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic limpa_modelo();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      last_read[k] = 8'h00;
      for (int a = 0; a < 8; a++) model[k][a] = 8'h00;
    end
  endtask

  // Monitor: pop one expectation per pronto/erro event and compare.
  task automatic monitor();
    exp_t e;
    int   n;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int k = 0; k < 2; k++) begin
          if (pr[k] || er[k]) begin
            n = (k == 0) ? q0.size() : q1.size();
            if (n == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious inst%0d: pronto=%0b erro=%0b with nothing expected (cycle %0d)",
                       k, pr[k], er[k], cyc);
            end else begin
              e = (k == 0) ? q0.pop_front() : q1.pop_front();
              chk("ciclo", k, cyc, e.ciclo);
              chk("pronto", k, {31'd0, pr[k]}, {31'd0, !e.so_erro});
              chk("erro", k, {31'd0, er[k]}, {31'd0, e.so_erro || e.prot});
              if (e.leit && !e.so_erro) last_read[k] = e.dado;
              chk("valor_saida", k, {24'd0, vs[k]}, {24'd0, last_read[k]});
              $display("inst%0d cycle %0d: %s data=%02h erro=%0b", k, cyc,
                       e.so_erro ? "collision" : (e.leit ? "read " : "write"), vs[k], er[k]);
            end
          end
        end
      end
    end
  endtask

  // Issue one request from a negedge; drive ignored noise while the instance is busy.
  task automatic do_req(int k, bit r, bit w, logic [2:0] a, logic [7:0] d, bit pbit);
    exp_t e;
    int   n = 0;
    while (oc[k]) begin
      rd[k] = 1'($urandom_range(0, 1));
      wr[k] = 1'($urandom_range(0, 1));
      ea[k] = 3'($urandom);
      wd[k] = 8'($urandom);
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("idle_timeout", k, 1, 0);
        break;
      end
    end
    rd[k] = r;
    wr[k] = w;
    ea[k] = a;
    wd[k] = d;
`ifdef MEMORIA_PROTECAO_EN
    prot[k] = 8'(pbit) << a;
`endif
    e.leit = r; e.so_erro = 1'b0; e.prot = 1'b0; e.dado = 8'h00;
    if (r ^ w) begin
      e.ciclo = cyc + lat_of(k) + 1;
      if (w) begin
        e.prot = pbit;
        if (!pbit) model[k][a] = d;
      end else begin
        e.dado = model[k][a];
      end
      push(k, e);
    end else if (r && w) begin
      e.so_erro = 1'b1;
      e.ciclo   = cyc + 1;
      push(k, e);
    end
    @(posedge clk);
    #1;
    if (r ^ w) chk("ocupado", k, {31'd0, oc[k]}, 1);
    @(negedge clk);
    rd[k] = 1'b0;
    wr[k] = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b0;
    rd = '0; wr = '0; ea = '0; wd = '0;
`ifdef MEMORIA_PROTECAO_EN
    prot = '0;
`endif
    limpa_modelo();
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_valor_saida", k, {24'd0, vs[k]}, 0);
      chk("rst_pronto", k, {31'd0, pr[k]}, 0);
      chk("rst_ocupado", k, {31'd0, oc[k]}, 0);
      chk("rst_erro", k, {31'd0, er[k]}, 0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Directed: read after reset, write/read, back-to-back, collision.
    do_req(0, 1, 0, 3'd5, 8'h00, 0);
    do_req(1, 1, 0, 3'd5, 8'h00, 0);
    do_req(0, 0, 1, 3'd1, 8'b10101010, 0);
    do_req(0, 1, 0, 3'd1, 8'h00, 0);
    do_req(1, 0, 1, 3'd7, 8'h5C, 0);
    do_req(1, 1, 0, 3'd7, 8'h00, 0);
    do_req(0, 1, 1, 3'd1, 8'h33, 0);
    do_req(0, 1, 0, 3'd1, 8'h00, 0);
    do_req(1, 1, 1, 3'd7, 8'h01, 0);
    do_req(1, 1, 0, 3'd7, 8'h00, 0);
`ifdef MEMORIA_PROTECAO_EN
    do_req(0, 0, 1, 3'd2, 8'h11, 1);
    do_req(0, 1, 0, 3'd2, 8'h00, 0);
`endif

    // Reset while a write of addr2=FF is in its wait states.
    repeat (6) @(negedge clk);
    rd[0] = 1'b0; wr[0] = 1'b1; ea[0] = 3'd2; wd[0] = 8'hFF;
    @(posedge clk);
    #2;
    wr[0] = 1'b0;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_valor_saida", k, {24'd0, vs[k]}, 0);
      chk("async_pronto", k, {31'd0, pr[k]}, 0);
      chk("async_ocupado", k, {31'd0, oc[k]}, 0);
      chk("async_erro", k, {31'd0, er[k]}, 0);
    end
    limpa_modelo();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_req(0, 1, 0, 3'd2, 8'h00, 0);

    // Randomized traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 60; i++) begin
        r = $urandom_range(0, 9);
        do_req(k, (r == 0) || (r >= 5), (r <= 4), 3'($urandom), 8'($urandom),
`ifdef MEMORIA_PROTECAO_EN
               1'($urandom_range(0, 3) == 0)
`else
               1'b0
`endif
               );
      end
    end

    repeat (20) @(negedge clk);
    chk("drain_q0", 0, q0.size(), 0);
    chk("drain_q1", 1, q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
